// File: rtl/break_accumulator.sv
// Break accumulator: sums masked break flags per candidate variable over one or
// more beats, then scans the candidates to find the one with the fewest breaks.
module break_accumulator #(
  parameter int CLUSTER_SIZE = 20,
  parameter int NSAT         = 3,
  parameter int CNT_W        = 8,
  localparam int IDX_W       = (NSAT > 1) ? $clog2(NSAT) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [CLUSTER_SIZE-1:0] break_i,
  input  logic [CLUSTER_SIZE-1:0] mask_i,
  input  logic                    last_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [IDX_W-1:0]        min_idx_o,
  output logic [CNT_W-1:0]        min_cnt_o,
  output logic                    zero_break_o
);

  localparam int PC_W  = $clog2(CLUSTER_SIZE + 1);
  localparam int SUM_W = CNT_W + PC_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCUM   = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  function automatic logic [PC_W-1:0] popcount(input logic [CLUSTER_SIZE-1:0] v);
    logic [PC_W-1:0] n;
    n = {PC_W{1'b0}};
    for (int i = 0; i < CLUSTER_SIZE; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  // Counters clamp at all-ones so a heavily broken candidate never looks cheap.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > CNT_MAX) begin
      return {CNT_W{1'b1}};
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] counters [NSAT];
  logic [IDX_W-1:0] cur_cand;
  logic [IDX_W-1:0] cmp_idx;
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cmp_val;
  logic [IDX_W-1:0] fin_idx;
  logic [CNT_W-1:0] fin_cnt;
  logic             cand_last;
  logic             cmp_last;
  logic             take;

  assign cand_last = (cur_cand == IDX_W'(NSAT - 1));
  assign cmp_last  = (cmp_idx == IDX_W'(NSAT - 1));

  // Next-state decode; a start in ACCUM restarts the round in place.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          next_state = ACCUM;
        end else begin
          next_state = IDLE;
        end
      end
      ACCUM: begin
        if (start_i) begin
          next_state = ACCUM;
        end else if (valid_i && last_i && cand_last) begin
          next_state = COMPARE;
        end else begin
          next_state = ACCUM;
        end
      end
      COMPARE: begin
        if (cmp_last) begin
          next_state = DONE;
        end else begin
          next_state = COMPARE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Beat arithmetic and one-candidate-per-cycle minimum scan.
  always_comb begin
    beat_cnt = sat_add(counters[cur_cand], popcount(break_i & mask_i));
    cmp_val  = counters[cmp_idx];
    take     = (cmp_idx == {IDX_W{1'b0}}) || (cmp_val < best_cnt);
    if (take) begin
      fin_idx = cmp_idx;
      fin_cnt = cmp_val;
    end else begin
      fin_idx = best_idx;
      fin_cnt = best_cnt;
    end
  end

  // State register and the status outputs derived from the next state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= IDLE;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= next_state;
      ready_o <= (next_state == ACCUM);
      busy_o  <= (next_state != IDLE);
      done_o  <= (next_state == DONE);
    end
  end

  // Counter accumulation, candidate sequencing and the compare scan.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NSAT; i++) begin
        counters[i] <= {CNT_W{1'b0}};
      end
      cur_cand <= {IDX_W{1'b0}};
      cmp_idx  <= {IDX_W{1'b0}};
      best_idx <= {IDX_W{1'b0}};
      best_cnt <= {CNT_W{1'b0}};
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (start_i) begin
            for (int i = 0; i < NSAT; i++) begin
              counters[i] <= {CNT_W{1'b0}};
            end
            cur_cand <= {IDX_W{1'b0}};
            cmp_idx  <= {IDX_W{1'b0}};
          end else if ((state == ACCUM) && valid_i) begin
            counters[cur_cand] <= beat_cnt;
            if (last_i && !cand_last) begin
              cur_cand <= cur_cand + IDX_W'(1'b1);
            end
          end
        end
        COMPARE: begin
          best_idx <= fin_idx;
          best_cnt <= fin_cnt;
          if (cmp_last) begin
            cmp_idx <= {IDX_W{1'b0}};
          end else begin
            cmp_idx <= cmp_idx + IDX_W'(1'b1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers load only as the scan finishes, then hold until the next one.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      min_idx_o    <= {IDX_W{1'b0}};
      min_cnt_o    <= {CNT_W{1'b0}};
      zero_break_o <= 1'b0;
    end else if ((state == COMPARE) && cmp_last) begin
      min_idx_o    <= fin_idx;
      min_cnt_o    <= fin_cnt;
      zero_break_o <= (fin_cnt == {CNT_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_break_accumulator.sv
// Randomized and directed bench for break_accumulator against a per-candidate
// sum/minimum model; CNT_W is reduced to 4 so saturation occurs often.
module tb_break_accumulator;
  localparam int CS = 20;
  localparam int NS = 3;
  localparam int CW = 4;
  localparam int IW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, valid, last;
  logic          ready, busy, done, zero;
  logic [CS-1:0] brk, msk;
  logic [IW-1:0] min_idx;
  logic [CW-1:0] min_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  int mcnt [NS];
  int mcur;
  int exp_ready, exp_busy, exp_done, exp_idx, exp_cnt, exp_zero;

  always #5 clk = ~clk;

  break_accumulator #(.CLUSTER_SIZE(CS), .NSAT(NS), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .valid_i(valid),
    .ready_o(ready), .break_i(brk), .mask_i(msk), .last_i(last),
    .busy_o(busy), .done_o(done), .min_idx_o(min_idx), .min_cnt_o(min_cnt),
    .zero_break_o(zero)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Every cycle, outputs must match the model's view of the round.
  always @(negedge clk) begin
    if (checking) begin
      chk("ready_o", ready, exp_ready);
      chk("busy_o", busy, exp_busy);
      chk("done_o", done, exp_done);
      chk("min_idx_o", min_idx, exp_idx);
      chk("min_cnt_o", min_cnt, exp_cnt);
      chk("zero_break_o", zero, exp_zero);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CS-1:0] ones(input int n);
    logic [CS-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NS; c++) mcnt[c] = 0;
    mcur = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
    exp_ready = 1; exp_busy = 1; exp_done = 0;
  endtask

  task automatic beat(input logic [CS-1:0] b, input logic [CS-1:0] m, input logic l);
    int s;
    repeat ($urandom_range(0, 1)) begin
      valid = 1'b0; brk = CS'($urandom); msk = CS'($urandom); last = 1'b1;
      step();
    end
    valid = 1'b1; brk = b; msk = m; last = l;
    step();
    valid = 1'b0; last = 1'b0;
    s = mcnt[mcur] + $countones(b & m);
    mcnt[mcur] = (s > CMAX) ? CMAX : s;
    if (l) mcur++;
    if (mcur == NS) exp_ready = 0;
  endtask

  task automatic junk_inputs(input bit junk);
    if (junk) begin
      valid = 1'b1; brk = CS'($urandom); msk = '1;
      last = 1'($urandom); start = 1'($urandom);
    end else begin
      valid = 1'b0; start = 1'b0; last = 1'b0;
    end
  endtask

  // Called just after the final beat edge: the block is in its first compare cycle.
  task automatic finish_round(input bit junk);
    int idx;
    for (int k = 0; k < NS - 1; k++) begin
      junk_inputs(junk);
      step();
    end
    idx = 0;
    for (int c = 1; c < NS; c++) if (mcnt[c] < mcnt[idx]) idx = c;
    junk_inputs(junk);
    step();
    exp_done = 1; exp_idx = idx; exp_cnt = mcnt[idx]; exp_zero = (mcnt[idx] == 0);
    junk_inputs(junk);
    step();
    exp_done = 0; exp_busy = 0;
    junk_inputs(1'b0);
  endtask

  task automatic rand_round(input bit restart);
    int nb;
    logic [CS-1:0] b, m;
    do_start();
    if (restart) begin
      repeat ($urandom_range(1, 3)) beat(CS'($urandom), CS'($urandom), 1'b0);
      start = 1'b1; valid = 1'b1; brk = '1; msk = '1;
      step();
      start = 1'b0; valid = 1'b0;
      model_clear();
    end
    for (int c = 0; c < NS; c++) begin
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        b = ($urandom_range(0, 3) == 0) ? CS'($urandom)
                                        : CS'($urandom & $urandom & $urandom);
        m = ($urandom_range(0, 4) == 0) ? '0 : CS'($urandom | $urandom);
        beat(b, m, k == nb - 1);
      end
    end
    finish_round(1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; brk = '0; msk = '0;
    exp_ready = 0; exp_busy = 0; exp_done = 0; exp_idx = 0; exp_cnt = 0; exp_zero = 0;
    model_clear();
    checking = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // Basic round: popcounts 5, 2, 7.
    do_start();
    beat(ones(5), '1, 1'b1);
    beat(ones(2), '1, 1'b1);
    beat(ones(7), '1, 1'b1);
    finish_round(1'b0);
    chk("basic idx", min_idx, 1);
    chk("basic cnt", min_cnt, 2);
    chk("basic zero", zero, 0);

    // Multi-beat with masked lane 0, three-way tie at 7.
    do_start();
    beat(ones(4), ~ones(1), 1'b0);
    beat(ones(4), '1, 1'b1);
    beat(ones(7), '1, 1'b1);
    beat(ones(3), '1, 1'b0);
    beat(ones(4), '1, 1'b1);
    finish_round(1'b1);
    chk("tie idx", min_idx, 0);
    chk("tie cnt", min_cnt, 7);

    // Freebie: fully masked single beat.
    do_start();
    beat(ones(5), '1, 1'b1);
    beat(ones(3), '1, 1'b1);
    beat('1, '0, 1'b1);
    finish_round(1'b0);
    chk("free idx", min_idx, 2);
    chk("free cnt", min_cnt, 0);
    chk("free zero", zero, 1);

    // Saturation: 20 beats of 20 to candidate 0 would wrap to 0 without clamping.
    do_start();
    for (int k = 0; k < 20; k++) beat(ones(20), '1, k == 19);
    beat(ones(20), '1, 1'b1);
    beat(ones(20), '1, 1'b1);
    finish_round(1'b1);
    chk("sat idx", min_idx, 0);
    chk("sat cnt", min_cnt, 15);

    // Restart mid-accumulation with a simultaneous beat that must be dropped.
    do_start();
    beat(ones(1), '1, 1'b1);
    start = 1'b1; valid = 1'b1; brk = '1; msk = '1; last = 1'b1;
    step();
    start = 1'b0; valid = 1'b0; last = 1'b0;
    model_clear();
    beat(ones(6), '1, 1'b1);
    beat(ones(4), '1, 1'b1);
    beat(ones(9), '1, 1'b1);
    finish_round(1'b1);
    chk("restart idx", min_idx, 1);
    chk("restart cnt", min_cnt, 4);

    // Asynchronous reset during compare: outputs clear at once, no done pulse.
    do_start();
    beat(ones(2), '1, 1'b1);
    beat(ones(3), '1, 1'b1);
    beat(ones(1), '1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst ready", ready, 0);
    chk("rst done", done, 0);
    chk("rst idx", min_idx, 0);
    chk("rst cnt", min_cnt, 0);
    chk("rst zero", zero, 0);
    exp_ready = 0; exp_busy = 0; exp_done = 0; exp_idx = 0; exp_cnt = 0; exp_zero = 0;
    step();
    step();
    reset = 1'b0;
    repeat (NS + 2) step();
    do_start();
    beat(ones(8), '1, 1'b1);
    beat(ones(6), '1, 1'b1);
    beat(ones(3), '1, 1'b1);
    finish_round(1'b0);
    chk("post-rst idx", min_idx, 2);
    chk("post-rst cnt", min_cnt, 3);

    for (int r = 0; r < 40; r++) begin
      rand_round($urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 2)) step();
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
